// File: rtl/oled_pkg.sv
// oled_pkg: SSD1306 opcodes, reset defaults, decoder/addressing enums and command-length helper
package oled_pkg;
  localparam logic [7:0] CMD_DISPLAY_OFF = 8'hAE, CMD_DISPLAY_ON = 8'hAF;
  localparam logic [7:0] CMD_ENTIRE_OFF = 8'hA4, CMD_ENTIRE_ON = 8'hA5;
  localparam logic [7:0] CMD_SEG_NORMAL = 8'hA0, CMD_SEG_REMAP = 8'hA1;
  localparam logic [7:0] CMD_COM_NORMAL = 8'hC0, CMD_COM_REV = 8'hC8;
  localparam logic [7:0] CMD_CONTRAST = 8'h81, CMD_CHARGE_PUMP = 8'h8D;
  localparam logic [7:0] CMD_PRECHARGE = 8'hD9, CMD_COM_PINS = 8'hDA;
  localparam logic [7:0] CMD_MEM_MODE = 8'h20, CMD_COL_ADDR = 8'h21, CMD_PAGE_ADDR = 8'h22;
  localparam logic [7:0] RST_CONTRAST = 8'h7F, RST_PRECHARGE = 8'h22, RST_COM_PINS = 8'h12;
  typedef enum logic [1:0] {ST_CMD, ST_PARAM1, ST_PARAM2} dec_state_e;
  typedef enum logic [1:0] {AM_HORIZ = 2'd0, AM_PAGE = 2'd2} addr_mode_e;
  typedef struct packed {
    logic display_on, charge_pump_en, seg_remap, com_scan_rev, entire_on;
    logic [7:0] contrast, precharge, com_pins;
    addr_mode_e mode;
  } cfg_t;
  localparam cfg_t CFG_RST = '{display_on: 1'b0, charge_pump_en: 1'b0, seg_remap: 1'b0,
                               com_scan_rev: 1'b0, entire_on: 1'b0, contrast: RST_CONTRAST,
                               precharge: RST_PRECHARGE, com_pins: RST_COM_PINS, mode: AM_PAGE};
  // total bytes of a command including parameters; 0 marks an unsupported opcode
  function automatic logic [1:0] cmd_len(input logic [7:0] b, input int pages);
    if (b inside {CMD_DISPLAY_OFF, CMD_DISPLAY_ON, CMD_ENTIRE_OFF, CMD_ENTIRE_ON, CMD_SEG_NORMAL,
                  CMD_SEG_REMAP, CMD_COM_NORMAL, CMD_COM_REV} || b <= 8'h17 ||
        (b[7:4] == 4'hB && 32'(b[3:0]) < pages)) return 2'd1;
    if (b inside {CMD_CONTRAST, CMD_CHARGE_PUMP, CMD_PRECHARGE, CMD_COM_PINS, CMD_MEM_MODE}) return 2'd2;
    return (b == CMD_COL_ADDR || b == CMD_PAGE_ADDR) ? 2'd3 : 2'd0;
  endfunction
endpackage

// File: rtl/oled_spi_responder_if.sv
// oled_spi_responder_if: OLED pin bundle, decoded status and frame-buffer read port
interface oled_spi_responder_if #(parameter int COLS = 128, parameter int PAGES = 4);
  localparam int PW = $clog2(PAGES), CW = $clog2(COLS), AW = $clog2(PAGES * COLS);
  logic oled_spi_clk, oled_spi_data, oled_dc_n, oled_reset_n, oled_vdd, oled_vbat;
  logic display_on, charge_pump_en, seg_remap, com_scan_rev, entire_on;
  logic [7:0] contrast, precharge, com_pins, rx_byte, fb_rd_data;
  logic [PW-1:0] page_ptr;
  logic [CW-1:0] col_ptr;
  logic [AW-1:0] fb_rd_addr;
  logic byte_strobe, rx_is_data, cmd_error, panel_active;
  modport master (
    output oled_spi_clk, oled_spi_data, oled_dc_n, oled_reset_n, oled_vdd, oled_vbat, fb_rd_addr,
    input  display_on, charge_pump_en, seg_remap, com_scan_rev, entire_on, contrast, precharge,
           com_pins, page_ptr, col_ptr, byte_strobe, rx_byte, rx_is_data, cmd_error, panel_active,
           fb_rd_data
  );
  modport slave (
    input  oled_spi_clk, oled_spi_data, oled_dc_n, oled_reset_n, oled_vdd, oled_vbat, fb_rd_addr,
    output display_on, charge_pump_en, seg_remap, com_scan_rev, entire_on, contrast, precharge,
           com_pins, page_ptr, col_ptr, byte_strobe, rx_byte, rx_is_data, cmd_error, panel_active,
           fb_rd_data
  );
endinterface

// File: rtl/oled_spi_deserializer.sv
// oled_spi_deserializer: pin synchronisers, SCLK rise detect, 8-bit count framing and D/C# capture
module oled_spi_deserializer #(parameter int SYNC_STAGES = 2) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       i_sclk,
  input  logic       i_sdin,
  input  logic       i_dc,
  input  logic       i_res_n,
  input  logic       i_vdd,
  input  logic       i_vbat,
  output logic       o_done,
  output logic [7:0] o_byte,
  output logic       o_dc,
  output logic       o_soft_rst,
  output logic       o_vbat
);
  logic [5:0] r_sync [SYNC_STAGES];
  logic [5:0] w_s;
  logic       r_sclk_d, w_rise;
  logic [2:0] r_cnt;
  logic [6:0] r_sh;
  assign w_s        = r_sync[SYNC_STAGES-1];
  assign w_rise     = w_s[0] & ~r_sclk_d;
  assign o_soft_rst = ~w_s[3] | w_s[4];
  assign o_vbat     = w_s[5];
  // sclk history keeps tracking through reset so a high SCLK at release is not taken as an edge
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
      r_sclk_d <= 1'b0;
      r_cnt    <= '0;
      r_sh     <= '0;
      o_done   <= 1'b0;
      o_byte   <= '0;
      o_dc     <= 1'b0;
    end else begin
      r_sync[0] <= {i_vbat, i_vdd, i_res_n, i_dc, i_sdin, i_sclk};
      for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
      r_sclk_d <= w_s[0];
      o_done   <= w_rise && r_cnt == 3'd7 && !o_soft_rst;
      if (o_soft_rst) r_cnt <= '0;
      else if (w_rise) begin
        r_cnt <= r_cnt + 3'd1;
        r_sh  <= {r_sh[5:0], w_s[1]};
        if (r_cnt == 3'd7) begin
          o_byte <= {r_sh, w_s[1]};
          o_dc   <= w_s[2];
        end
      end
    end
endmodule

// File: rtl/oled_spi_responder.sv
// oled_spi_responder: SSD1306 SPI receiver, command decoder and frame buffer (frame buffer built with OLED_RX_FB_EN)
module oled_spi_responder import oled_pkg::*; #(
  parameter int COLS = 128,
  parameter int PAGES = 4,
  parameter int SYNC_STAGES = 2
) (
  input logic clock,
  input logic reset_n,
  oled_spi_responder_if.slave bus
);
  localparam int PW = $clog2(PAGES), CW = $clog2(COLS);
  localparam logic [PW-1:0] PG_LAST = PW'(PAGES - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  logic          w_done, w_dc, w_soft, w_vbat, w_err, w_hit;
  logic [7:0]    w_byte, r_op, r_p1, r_rx;
  logic [1:0]    w_len;
  dec_state_e    r_state, w_state_n;
  cfg_t          r_cfg;
  logic [PW-1:0] r_page, r_pg_start, r_pg_end, w_page_nx;
  logic [CW-1:0] r_col, r_col_start, r_col_end, w_col_nx;
  logic          r_strobe, r_rx_dc, r_err;
  oled_spi_deserializer #(.SYNC_STAGES(SYNC_STAGES)) u_des (
    .clock(clock), .reset_n(reset_n), .i_sclk(bus.oled_spi_clk), .i_sdin(bus.oled_spi_data),
    .i_dc(bus.oled_dc_n), .i_res_n(bus.oled_reset_n), .i_vdd(bus.oled_vdd), .i_vbat(bus.oled_vbat),
    .o_done(w_done), .o_byte(w_byte), .o_dc(w_dc), .o_soft_rst(w_soft), .o_vbat(w_vbat)
  );
  always_comb begin
    w_state_n = r_state;
    w_err     = 1'b0;
    w_len     = cmd_len(w_byte, PAGES);
    if (w_done) begin
      if (w_dc) begin
        w_state_n = ST_CMD;
        w_err     = r_state != ST_CMD;
      end else if (r_state == ST_CMD) begin
        w_state_n = w_len > 2'd1 ? ST_PARAM1 : ST_CMD;
        w_err     = w_len == 2'd0;
      end else if (r_state == ST_PARAM1) begin
        w_state_n = cmd_len(r_op, PAGES) == 2'd3 ? ST_PARAM2 : ST_CMD;
        w_err     = r_op == CMD_MEM_MODE && w_byte[0];
      end else w_state_n = ST_CMD;
    end
  end
  // horizontal mode wraps at the programmed column window; page mode wraps across the full row
  assign w_hit     = r_cfg.mode == AM_HORIZ && r_col == r_col_end;
  assign w_col_nx  = w_hit ? r_col_start : (r_col == COL_LAST ? '0 : r_col + 1'b1);
  assign w_page_nx = !w_hit ? r_page : (r_page == r_pg_end ? r_pg_start : r_page + 1'b1);
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      r_cfg <= CFG_RST; r_state <= ST_CMD; r_op <= '0; r_p1 <= '0; r_page <= '0; r_col <= '0;
      r_pg_start <= '0; r_pg_end <= PG_LAST; r_col_start <= '0; r_col_end <= COL_LAST;
      r_strobe <= 1'b0; r_rx <= '0; r_rx_dc <= 1'b0;
    end else if (w_soft) begin
      r_cfg <= CFG_RST; r_state <= ST_CMD; r_op <= '0; r_p1 <= '0; r_page <= '0; r_col <= '0;
      r_pg_start <= '0; r_pg_end <= PG_LAST; r_col_start <= '0; r_col_end <= COL_LAST;
      r_strobe <= 1'b0; r_rx <= '0; r_rx_dc <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_strobe <= w_done;
      if (w_done) begin
        r_rx    <= w_byte;
        r_rx_dc <= w_dc;
      end
      if (w_done && w_dc) begin
        r_page <= w_page_nx;
        r_col  <= w_col_nx;
      end else if (w_done && r_state == ST_CMD) begin
        r_op <= w_byte;
        case (w_byte)
          CMD_DISPLAY_OFF, CMD_DISPLAY_ON: r_cfg.display_on   <= w_byte[0];
          CMD_ENTIRE_OFF, CMD_ENTIRE_ON:   r_cfg.entire_on    <= w_byte[0];
          CMD_SEG_NORMAL, CMD_SEG_REMAP:   r_cfg.seg_remap    <= w_byte[0];
          CMD_COM_NORMAL, CMD_COM_REV:     r_cfg.com_scan_rev <= w_byte[3];
          default: begin
            if (w_byte[7:4] == 4'h0) r_col[3:0] <= w_byte[3:0];
            if (w_byte[7:3] == 5'b00010) r_col[6:4] <= w_byte[2:0];
            if (w_byte[7:4] == 4'hB && 32'(w_byte[3:0]) < PAGES) r_page <= PW'(w_byte[3:0]);
          end
        endcase
      end else if (w_done && r_state == ST_PARAM1) begin
        r_p1 <= w_byte;
        case (r_op)
          CMD_CONTRAST:    r_cfg.contrast       <= w_byte;
          CMD_CHARGE_PUMP: r_cfg.charge_pump_en <= w_byte[2];
          CMD_PRECHARGE:   r_cfg.precharge      <= w_byte;
          CMD_COM_PINS:    r_cfg.com_pins       <= w_byte;
          CMD_MEM_MODE:    if (!w_byte[0]) r_cfg.mode <= w_byte[1] ? AM_PAGE : AM_HORIZ;
          default: ;
        endcase
      end else if (w_done && r_op == CMD_PAGE_ADDR) begin
        r_pg_start <= PW'(r_p1);
        r_pg_end   <= PW'(w_byte);
        r_page     <= PW'(r_p1);
        r_col      <= r_col_start;
      end else if (w_done) begin
        r_col_start <= CW'(r_p1);
        r_col_end   <= CW'(w_byte);
        r_col       <= CW'(r_p1);
        r_page      <= r_pg_start;
      end
    end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) r_err <= 1'b0;
    else if (!w_soft && w_err) r_err <= 1'b1;
`ifdef OLED_RX_FB_EN
  logic [7:0] r_fb [PAGES*COLS];
  logic [7:0] r_rd;
  always_ff @(posedge clock) begin
    if (w_done && w_dc && !w_soft) r_fb[{r_page, r_col}] <= w_byte;
    r_rd <= r_fb[bus.fb_rd_addr];
  end
  assign bus.fb_rd_data = r_rd;
`else
  assign bus.fb_rd_data = 8'h00;
`endif
  assign bus.display_on     = r_cfg.display_on;
  assign bus.charge_pump_en = r_cfg.charge_pump_en;
  assign bus.seg_remap      = r_cfg.seg_remap;
  assign bus.com_scan_rev   = r_cfg.com_scan_rev;
  assign bus.entire_on      = r_cfg.entire_on;
  assign bus.contrast       = r_cfg.contrast;
  assign bus.precharge      = r_cfg.precharge;
  assign bus.com_pins       = r_cfg.com_pins;
  assign bus.page_ptr       = r_page;
  assign bus.col_ptr        = r_col;
  assign bus.byte_strobe    = r_strobe;
  assign bus.rx_byte        = r_rx;
  assign bus.rx_is_data     = r_rx_dc;
  assign bus.cmd_error      = r_err;
  assign bus.panel_active   = r_cfg.display_on & r_cfg.charge_pump_en & ~w_vbat;
endmodule

// File: tb/tb_oled_spi_responder.sv
// tb_oled_spi_responder: byte scoreboard plus register/pointer/frame-buffer checks for oled_spi_responder
module tb_oled_spi_responder;
  localparam int SYNC = 2;
  logic clock = 1'b0, reset_n = 1'b0;
  int errors = 0, checks = 0;
  logic [8:0] sb_q[$];
  logic [7:0] init_seq [12] = '{8'hAE, 8'h8D, 8'h14, 8'hD9, 8'hF1, 8'h81, 8'hFF, 8'hA0, 8'hC0, 8'hDA, 8'h00, 8'hAF};
  logic [7:0] horiz_seq [8] = '{8'h20, 8'h00, 8'h21, 8'h7E, 8'h7F, 8'h22, 8'h00, 8'h01};
  oled_spi_responder_if #(.COLS(128), .PAGES(4)) bus();
  oled_spi_responder #(.COLS(128), .PAGES(4), .SYNC_STAGES(SYNC)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));
  always #5 clock = ~clock;

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic dc);
    int n;
    sb_q.push_back({dc, b});
    for (int i = 7; i >= 0; i--) begin
      bus.oled_spi_data = b[i];
      bus.oled_dc_n = dc;
      repeat (5) @(negedge clock);
      bus.oled_spi_clk = 1'b1;
      if (i == 0) begin
        n = 0;
        while (n < 12 && !bus.byte_strobe) begin
          @(posedge clock);
          #1 n++;
        end
        check("strobe_latency", n, SYNC + 2);
      end
      repeat (5) @(negedge clock);
      bus.oled_spi_clk = 1'b0;
    end
    repeat (3) @(negedge clock);
  endtask

`ifdef OLED_RX_FB_EN
  task automatic check_fb(input int addr, input int exp);
    @(negedge clock);
    bus.fb_rd_addr = 9'(addr);
    @(posedge clock);
    #1 check($sformatf("fb[%0d]", addr), bus.fb_rd_data, exp);
  endtask
`endif

  always @(negedge clock)
    if (bus.byte_strobe) begin
      if (sb_q.size() == 0) check("unexpected_strobe", 1, 0);
      else begin
        logic [8:0] e;
        e = sb_q.pop_front();
        check("rx_byte", bus.rx_byte, e[7:0]);
        check("rx_is_data", bus.rx_is_data, e[8]);
      end
    end

  initial begin
    #1ms;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    bus.oled_spi_clk = 0; bus.oled_spi_data = 0; bus.oled_dc_n = 0;
    bus.oled_reset_n = 1; bus.oled_vdd = 0; bus.oled_vbat = 0; bus.fb_rd_addr = '0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    check("rst_display_on", bus.display_on, 0);
    check("rst_contrast", bus.contrast, 8'h7F);
    check("rst_precharge", bus.precharge, 8'h22);
    check("rst_com_pins", bus.com_pins, 8'h12);
    check("rst_page", bus.page_ptr, 0);
    check("rst_col", bus.col_ptr, 0);
    check("rst_strobe", bus.byte_strobe, 0);
    check("rst_cmd_error", bus.cmd_error, 0);
    foreach (init_seq[i]) send(init_seq[i], 1'b0);
    check("init_display_on", bus.display_on, 1);
    check("init_charge_pump", bus.charge_pump_en, 1);
    check("init_precharge", bus.precharge, 8'hF1);
    check("init_contrast", bus.contrast, 8'hFF);
    check("init_com_pins", bus.com_pins, 8'h00);
    check("init_seg_remap", bus.seg_remap, 0);
    check("init_panel_active", bus.panel_active, 1);
    check("init_cmd_error", bus.cmd_error, 0);
    bus.oled_vbat = 1'b1;
    repeat (5) @(negedge clock);
    check("vbat_off_panel", bus.panel_active, 0);
    bus.oled_vbat = 1'b0;
    repeat (5) @(negedge clock);
    send(8'h22, 0); send(8'h01, 0); send(8'h02, 0); send(8'h10, 0);
    for (int i = 0; i < 8; i++) send(8'h3C, 1'b1);
    check("pa_page", bus.page_ptr, 1);
    check("pa_col", bus.col_ptr, 8);
`ifdef OLED_RX_FB_EN
    check_fb(128, 8'h3C);
    check_fb(135, 8'h3C);
`endif
    send(8'h0F, 0); send(8'h17, 0);
    check("col_set_127", bus.col_ptr, 127);
    send(8'hAA, 1); send(8'h55, 1);
    check("wrap_page", bus.page_ptr, 1);
    check("wrap_col", bus.col_ptr, 1);
`ifdef OLED_RX_FB_EN
    check_fb(255, 8'hAA);
    check_fb(128, 8'h55);
`endif
    foreach (horiz_seq[i]) send(horiz_seq[i], 1'b0);
    check("hz_start_page", bus.page_ptr, 0);
    check("hz_start_col", bus.col_ptr, 126);
    for (int i = 1; i <= 5; i++) send(8'(i), 1'b1);
    check("hz_end_page", bus.page_ptr, 0);
    check("hz_end_col", bus.col_ptr, 127);
    check("hz_cmd_error", bus.cmd_error, 0);
`ifdef OLED_RX_FB_EN
    check_fb(126, 8'h05);
    check_fb(127, 8'h02);
    check_fb(254, 8'h03);
    check_fb(255, 8'h04);
`else
    check("fb_tied_zero", bus.fb_rd_data, 0);
`endif
    for (int i = 0; i < 5; i++) begin
      bus.oled_spi_data = 1'b1;
      repeat (5) @(negedge clock);
      bus.oled_spi_clk = 1'b1;
      repeat (5) @(negedge clock);
      bus.oled_spi_clk = 1'b0;
    end
    repeat (5) @(negedge clock);
    bus.oled_reset_n = 1'b0;
    repeat (6) @(negedge clock);
    bus.oled_reset_n = 1'b1;
    repeat (6) @(negedge clock);
    check("pr_display_on", bus.display_on, 0);
    check("pr_charge_pump", bus.charge_pump_en, 0);
    check("pr_contrast", bus.contrast, 8'h7F);
    check("pr_precharge", bus.precharge, 8'h22);
    check("pr_com_pins", bus.com_pins, 8'h12);
    check("pr_page", bus.page_ptr, 0);
    check("pr_col", bus.col_ptr, 0);
    check("pr_rx_byte", bus.rx_byte, 0);
    check("pr_sb_empty", sb_q.size(), 0);
    send(8'hAF, 0);
    check("pr_af_display_on", bus.display_on, 1);
    send(8'h81, 0); send(8'h99, 1);
    check("err_cmd_error", bus.cmd_error, 1);
    check("err_contrast", bus.contrast, 8'h7F);
    check("err_col", bus.col_ptr, 1);
`ifdef OLED_RX_FB_EN
    check_fb(0, 8'h99);
`endif
    send(8'h81, 0); send(8'h40, 0);
    check("recover_contrast", bus.contrast, 8'h40);
    repeat (10) @(negedge clock);
    check("sb_leftover", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/oled_spi_responder.md
# oled_spi_responder

Receive-side counterpart of the ZedBoard OLED SPI command/data stream. The block samples the 4-wire write-only link (SCLK, SDIN, D/C#, RES#) with the 100 MHz system clock and deserialises bytes. It decodes the SSD1306 command subset the display path emits, tracks the configuration registers, and writes data bytes into a 128x32 page-organised frame buffer. It serves as the synthesizable display model for loop-back verification of the OLED transmitter, and as an on-chip bus monitor.

## Interface
- COLS, 128, columns per page
- PAGES, 4, pages of 8 rows each
- SYNC_STAGES, 2, synchroniser depth on all pin inputs
- clock  in  1  100 MHz system clock
- reset_n  in  1  block reset; asynchronous assert, active-low
- oled_spi_clk  in  1  serial clock; data sampled on rising edge, MSB first
- oled_spi_data  in  1  serial data
- oled_dc_n  in  1  0 = command byte, 1 = data byte; sampled with bit 0
- oled_reset_n  in  1  display reset pin, active-low
- oled_vdd  in  1  logic supply enable, 0 = on
- oled_vbat  in  1  panel supply enable, 0 = on
- display_on, charge_pump_en, seg_remap, com_scan_rev, entire_on  out  1  decoded flags
- contrast, precharge, com_pins  out  8  decoded parameter registers
- page_ptr  out  $clog2(PAGES)  current write page
- col_ptr  out  $clog2(COLS)  current write column
- byte_strobe  out  1  one-cycle pulse per received byte
- rx_byte  out  8  last received byte
- rx_is_data  out  1  D/C# of rx_byte
- cmd_error  out  1  sticky protocol-error flag
- panel_active  out  1  display_on & charge_pump_en & !oled_vbat
- fb_rd_addr  in  $clog2(PAGES*COLS)  frame-buffer read address (macro only)
- fb_rd_data  out  8  read data, 1-cycle latency (macro only)

## Operation
- Reset values (reset_n low, or synchronised oled_reset_n low, or oled_vdd high):
  - display_on=0, charge_pump_en=0, contrast=0x7F, precharge=0x22, com_pins=0x12.
  - seg_remap=0, com_scan_rev=0, entire_on=0.
  - page_ptr=0, col_ptr=0; page range 0..PAGES-1, column range 0..COLS-1; page addressing mode.
  - Bit counter=0, decoder in CMD, byte_strobe=0, rx_byte=0, rx_is_data=0.
- cmd_error is cleared only by reset_n. Frame-buffer contents survive oled_reset_n.
- Deserialiser: 3-bit counter. The 8th sampled rising edge completes a byte and captures oled_dc_n. There is no chip select; framing is by count only.
- Decoder FSM states: CMD, PARAM1, PARAM2.
- CMD, one-byte commands:
  - AE/AF: display_on.
  - A4/A5: entire_on.
  - A0/A1: seg_remap.
  - C0/C8: com_scan_rev.
  - 00-0F: col_ptr[3:0].
  - 10-17: col_ptr[6:4].
  - B0+n: page_ptr=n for n<PAGES.
- CMD, two-byte commands (go to PARAM1, update on parameter):
  - 81: contrast.
  - 8D: charge_pump_en=param[2].
  - D9: precharge.
  - DA: com_pins.
  - 20: mode (0 = horizontal, 2 = page; 1/3 set cmd_error and keep mode).
- CMD, three-byte commands: 22 (page start/end, masked to page width) and 21 (column start/end). On the second parameter, page_ptr←page start and col_ptr←column start in either mode.
- Any other command byte sets cmd_error; the byte is ignored and the FSM stays in CMD.
- Data byte in PARAM1/PARAM2: sets cmd_error, discards the pending command with no register update, then is written as normal data.
- Data write: fb[page_ptr*COLS+col_ptr]←byte.
  - Page mode: col_ptr increments, wrapping COLS-1→0; page is unchanged.
  - Horizontal mode: at column end, col_ptr←column start and page_ptr advances, wrapping page end→page start.

## Timing
- spi_clk high and low phases must each be ≥3 clock periods (nominal link 10 MHz = 5 periods).
- 8th SCLK rising edge at pin → byte_strobe high exactly SYNC_STAGES+2 clock edges later.
- Register, pointer and frame-buffer updates are visible on the same edge byte_strobe rises.
- oled_reset_n assertion takes effect SYNC_STAGES+1 cycles after the pin falls. It overrides a byte completing in the same cycle; that byte is dropped with no strobe.
- SCLK edges are ignored while reset is active.
- fb_rd_data is valid one cycle after fb_rd_addr. When a read and a write hit the same address in the same cycle, old data is returned.

## Configuration
- OLED_RX_FB_EN defined: the PAGES*COLS x 8 frame buffer and the fb_rd_* port are built.
- OLED_RX_FB_EN undefined: no memory; fb_rd_data ties to 0. Pointers still advance, and data is observable only via byte_strobe/rx_byte.

## Structure
- Shared package oled_pkg holds:
  - Command opcodes (CMD_DISPLAY_OFF=0xAE, CMD_CHARGE_PUMP=0x8D, CMD_PAGE_ADDR=0x22, etc.).
  - Reset-default constants.
  - The decoder-state enum and the addressing-mode enum.
- One sub-module: oled_spi_deserializer, containing the synchronisers, edge detect, bit counter, and byte/dc capture.

## Test plan
- Transmitter init sequence AE,8D,14,D9,F1,81,FF,A0,C0,DA,00,AF with oled_vbat=0 → display_on=1, charge_pump_en=1, precharge=0xF1, contrast=0xFF, com_pins=0x00, panel_active=1, cmd_error=0.
- Command 22,01,02,10 then 8 data bytes 0x3C → page_ptr=1, fb[128..135]=0x3C, col_ptr=8.
- Page mode with col_ptr=127, two data bytes 0xAA,0x55 → fb[page*128+127]=0xAA, fb[page*128+0]=0x55, page unchanged.
- Horizontal mode 20,00; 21,7E,7F; 22,00,01; five data bytes → writes at (0,126),(0,127),(1,126),(1,127),(0,126).
- Command 81, then a data byte 0x99 → cmd_error=1, contrast stays 0x7F, byte written at the current pointer.
- Five SCLK bits, then pulse oled_reset_n low, then byte AF → no strobe for the partial byte, all registers at defaults, display_on=1 after AF.
